pe_window_dist: RTL

//  Parametrised successor to the fixed 8-PE row distributor. Takes one element-serial packet and fans it out into NUM_PE
//  per-PE window buffers with a configurable stride: PE p receives e[p*STRIDE + j] for j = 0..WIN-1.

---
 rtl/pe_window_dist_if.sv | 30 +++
 rtl/pe_window_dist.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pe_window_dist_if.sv
// Write/read bus of the PE window distributor.
// The packet source and PE array sit on the master side, the distributor on the slave side.
interface pe_window_dist_if #(
  parameter int NUM_PE = 8,
  parameter int ELEM_W = 16
);
  logic                           wr_sop;
  logic                           wr_eop;
  logic                           wr_vld;
  logic                           wr_rdy;
  logic [ELEM_W-1:0]              wr_data;
  logic                           err_data;
  logic                           rd_start;
  logic                           buf_rdy;
  logic                           rd_busy;
  logic                           pe_vld;
  logic                           pe_last;
  logic [NUM_PE-1:0][ELEM_W-1:0]  pe_data;
  logic                           pkt_drop;

  modport master (
    output wr_sop, wr_eop, wr_vld, wr_data, err_data, rd_start,
    input  wr_rdy, buf_rdy, rd_busy, pe_vld, pe_last, pe_data, pkt_drop
  );

  modport slave (
    input  wr_sop, wr_eop, wr_vld, wr_data, err_data, rd_start,
    output wr_rdy, buf_rdy, rd_busy, pe_vld, pe_last, pe_data, pkt_drop
  );
endinterface

// File: rtl/pe_window_dist.sv
// PE window distributor: fans one element-serial packet out into NUM_PE
// ping-pong window buffers (PE p gets e[p*STRIDE + j], j < WIN) and streams
// committed windows to the PE array, one slot per cycle.

// One lane: two banks of WIN elements plus a registered read port.
module pe_window_lane #(
  parameter int ELEM_W = 16,
  parameter int WIN    = 6,
  parameter int OW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              wbank_i,
  input  logic [OW-1:0]     woff_i,
  input  logic [ELEM_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic              rbank_i,
  input  logic [OW-1:0]     roff_i,
  output logic [ELEM_W-1:0] rdata_o
);
  logic [ELEM_W-1:0] mem_q [2][WIN];
  logic [ELEM_W-1:0] rdata_q;

  // Bank storage; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wbank_i][woff_i] <= wdata_i;
  end

  // Read register holds the last slot while no read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[rbank_i][roff_i];
  end

  assign rdata_o = rdata_q;
endmodule

module pe_window_dist #(
  parameter int NUM_PE = 8,
  parameter int ELEM_W = 16,
  parameter int WIN    = 6,
  parameter int STRIDE = 1
) (
  input  logic            clk,
  input  logic            rst,
  pe_window_dist_if.slave bus
);
  localparam int PKT_LEN = (NUM_PE-1)*STRIDE + WIN;
  localparam int IW      = $clog2(PKT_LEN+1);
  localparam int SW      = $clog2(WIN+1);
  localparam int OW      = $clog2(WIN);

  typedef enum logic {W_IDLE, W_FILL} w_st_t;
  typedef enum logic {R_IDLE, R_RUN}  r_st_t;

  w_st_t         w_state_q;
  r_st_t         r_state_q;
  logic [IW-1:0] idx_q;
  logic          wbank_q, rbank_q;
  logic [1:0]    full_q, full_d;
  logic          drop_q;
  logic [SW-1:0] slot_q;
  logic          busy_q, vld_q, last_q;

  logic          wr_rdy, acc, in_pkt, commit, drop;
  logic [IW-1:0] cur_i, cnt;
  logic          rd_go, release_w, rd_en;
  logic [OW-1:0] rd_off;

  assign wr_rdy    = ~full_q[wbank_q];
  assign acc       = bus.wr_vld & wr_rdy;
  // A beat belongs to a packet if it opens one or continues the current one.
  assign in_pkt    = acc & (bus.wr_sop | (w_state_q == W_FILL));
  assign cur_i     = bus.wr_sop ? '0 : idx_q;
  assign cnt       = (cur_i == IW'(PKT_LEN)) ? cur_i : cur_i + 1'b1;
  assign commit    = in_pkt & bus.wr_eop & ~bus.err_data & (cnt == IW'(PKT_LEN));
  // A sop mid-fill kills the open packet even if the new beat is also eop.
  assign drop      = (acc & bus.wr_sop & (w_state_q == W_FILL)) |
                     (in_pkt & bus.wr_eop & ~commit);

  assign rd_go     = bus.rd_start & (|full_q) & ~busy_q;
  assign release_w = (r_state_q == R_RUN) & (slot_q == SW'(WIN));
  assign rd_en     = rd_go | ((r_state_q == R_RUN) & (slot_q < SW'(WIN)));
  assign rd_off    = rd_go ? '0 : OW'(slot_q);

  // Write FSM: packet framing, element index and write-bank pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      idx_q     <= '0;
      wbank_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      drop_q <= drop;
      if (in_pkt) begin
        if (bus.wr_eop) begin
          w_state_q <= W_IDLE;
          if (commit) wbank_q <= ~wbank_q;
        end else begin
          w_state_q <= W_FILL;
          idx_q     <= cnt;
        end
      end
    end
  end

  // Commit of one bank and release of the other can land on the same edge.
  always_comb begin
    full_d = full_q;
    if (commit)    full_d[wbank_q] = 1'b1;
    if (release_w) full_d[rbank_q] = 1'b0;
  end

  // Bank occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) full_q <= '0;
    else     full_q <= full_d;
  end

  // Read FSM: slot 0 is issued with rd_start, the extra RUN cycle releases the bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      slot_q    <= '0;
      rbank_q   <= 1'b0;
      busy_q    <= 1'b0;
      vld_q     <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      vld_q  <= rd_en;
      last_q <= rd_en & (rd_off == OW'(WIN-1));
      case (r_state_q)
        R_IDLE: if (rd_go) begin
          r_state_q <= R_RUN;
          slot_q    <= SW'(1);
          busy_q    <= 1'b1;
        end
        R_RUN: if (release_w) begin
          r_state_q <= R_IDLE;
          slot_q    <= '0;
          busy_q    <= 1'b0;
          rbank_q   <= ~rbank_q;
        end else begin
          slot_q <= slot_q + 1'b1;
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // Per-PE window lanes: element i lands at offset i - p*STRIDE when in window.
  for (genvar p = 0; p < NUM_PE; p++) begin : g_lane
    logic          we;
    logic [OW-1:0] woff;
    assign we   = in_pkt & (cur_i >= IW'(p*STRIDE)) &
                  (cur_i < IW'(p*STRIDE + WIN)) & (cur_i < IW'(PKT_LEN));
    assign woff = OW'(cur_i - IW'(p*STRIDE));
    pe_window_lane #(.ELEM_W(ELEM_W), .WIN(WIN), .OW(OW)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .we_i    (we),
      .wbank_i (wbank_q),
      .woff_i  (woff),
      .wdata_i (bus.wr_data),
      .re_i    (rd_en),
      .rbank_i (rbank_q),
      .roff_i  (rd_off),
      .rdata_o (bus.pe_data[p])
    );
  end

  assign bus.wr_rdy   = wr_rdy;
  assign bus.buf_rdy  = |full_q;
  assign bus.rd_busy  = busy_q;
  assign bus.pe_vld   = vld_q;
  assign bus.pe_last  = last_q;
  assign bus.pkt_drop = drop_q;
endmodule
